serial_cmp_ctrl: RTL and testbench



---
 rtl/serial_cmp_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl.sv
// MSB-first multi-bit magnitude comparator built around one external 1-bit comparator.
// Define SERIAL_CMP_SIGNED_EN to treat the operands as two's complement.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic             scanning;
    logic             eq_like;
    logic             sign_swap;

    assign scanning = (state_q == SCAN);

    // A comparator that reports nothing is treated as reporting equality.
    assign eq_like = cmp_eq | ~(cmp_gt | cmp_lt);

`ifdef SERIAL_CMP_SIGNED_EN
    // The sign bit carries negative weight, so its decision is inverted.
    assign sign_swap = (idx_q == IDX_W'(WIDTH - 1));
`else
    assign sign_swap = 1'b0;
`endif

    assign cmp_a  = scanning ? a_q[idx_q] : 1'b0;
    assign cmp_b  = scanning ? b_q[idx_q] : 1'b0;
    assign busy   = busy_q;
    assign done   = done_q;
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign a_lt_b = lt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        idx_q   <= IDX_W'(WIDTH - 1);
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if (cmp_gt) begin
                        if (sign_swap) lt_q <= 1'b1;
                        else           gt_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cmp_lt) begin
                        if (sign_swap) gt_q <= 1'b1;
                        else           lt_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (eq_like && (idx_q == '0)) begin
                        eq_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl driving a behavioural 1-bit comparator.
module tb_serial_cmp_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             cmp_a, cmp_b;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic             busy, done, a_gt_b, a_eq_b, a_lt_b;

    typedef struct packed {
        logic [2:0] res;   // {gt, eq, lt}
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign cmp_gt = cmp_a & ~cmp_b;
    assign cmp_eq = ~(cmp_a ^ cmp_b);
    assign cmp_lt = ~cmp_a & cmp_b;

    serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.lat = 8'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                e.lat = 8'(WIDTH - i);
                break;
            end
        end
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b))      e.res = 3'b100;
        else if ($signed(a) < $signed(b)) e.res = 3'b001;
        else                              e.res = 3'b010;
`else
        if (a > b)      e.res = 3'b100;
        else if (a < b) e.res = 3'b001;
        else            e.res = 3'b010;
`endif
        return e;
    endfunction

    // Drive a request at a falling edge and return one falling edge after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < WIDTH + 4) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, a_gt_b, a_eq_b, a_lt_b, cmp_a, cmp_b} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000",
                     {busy, done, a_gt_b, a_eq_b, a_lt_b, cmp_a, cmp_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 00", {busy, done});
        end
    endtask

    task automatic test_gt_msb;
        exp_t e;
        int   cyc;
        launch(8'hA5, 8'h25);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL gt_busy got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat)) begin
            errors++;
            $display("FAIL gt_latency got done=%b cyc=%0d want 1 cyc=%0d", done, cyc, e.lat);
        end
        checks++;
        if ({a_gt_b, a_eq_b, a_lt_b} !== e.res || busy !== 1'b0) begin
            errors++;
            $display("FAIL gt_result got %b busy=%b want %b busy=0", {a_gt_b, a_eq_b, a_lt_b}, busy, e.res);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL gt_hold got done=%b res=%b want done=0 res=%b", done, {a_gt_b, a_eq_b, a_lt_b}, e.res);
        end
    endtask

    task automatic test_eq_walk;
        exp_t             e;
        logic [WIDTH-1:0] a, b;
        a = 8'h3C;
        b = 8'h3C;
        launch(a, b);
        e = sb.pop_front();
        for (int i = WIDTH - 1; i >= 0; i--) begin
            checks++;
            if (cmp_a !== a[i] || cmp_b !== b[i] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL eq_walk bit%0d got a=%b b=%b busy=%b done=%b want a=%b b=%b busy=1 done=0",
                         i, cmp_a, cmp_b, busy, done, a[i], b[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || {a_gt_b, a_eq_b, a_lt_b} !== e.res || int'(e.lat) != WIDTH) begin
            errors++;
            $display("FAIL eq_result got done=%b res=%b want done=1 res=%b", done, {a_gt_b, a_eq_b, a_lt_b}, e.res);
        end
        checks++;
        if (cmp_a !== 1'b0 || cmp_b !== 1'b0) begin
            errors++;
            $display("FAIL eq_cmp_idle got %b%b want 00", cmp_a, cmp_b);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        launch(8'h10, 8'h11);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL b2b_first got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        launch(8'h01, 8'h00);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || {a_gt_b, a_eq_b, a_lt_b} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_accept got done=%b busy=%b res=%b want 0 1 000",
                     done, busy, {a_gt_b, a_eq_b, a_lt_b});
        end
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL b2b_second got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        exp_t e;
        int   cyc;
        launch(8'h00, 8'h00);
        repeat (2) @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc + 3 != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL busy_start got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc + 3, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan;
        exp_t e;
        int   cyc;
        bit   saw_done;
        launch(8'h00, 8'h01);
        e = sb.pop_front();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, a_gt_b, a_eq_b, a_lt_b, cmp_a, cmp_b} !== 7'b0) begin
            errors++;
            $display("FAIL midscan_reset got %b want 0000000",
                     {busy, done, a_gt_b, a_eq_b, a_lt_b, cmp_a, cmp_b});
        end
        saw_done = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midscan_no_done got 1 want 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        launch(8'h00, 8'h01);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL restart got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_msb_sign;
        exp_t e;
        int   cyc;
        launch(8'h80, 8'h01);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL msb_sign got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        launch(8'h7E, 8'h7F);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
            errors++;
            $display("FAIL lsb_decide got done=%b cyc=%0d res=%b want 1 %0d %b",
                     done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        exp_t             e;
        int               cyc;
        logic [WIDTH-1:0] a, b;
        for (int n = 0; n < 12; n++) begin
            a = WIDTH'($urandom);
            b = (n % 3 == 0) ? a : WIDTH'($urandom);
            launch(a, b);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (done !== 1'b1 || cyc != int'(e.lat) || {a_gt_b, a_eq_b, a_lt_b} !== e.res) begin
                errors++;
                $display("FAIL random a=%h b=%h got done=%b cyc=%0d res=%b want 1 %0d %b",
                         a, b, done, cyc, {a_gt_b, a_eq_b, a_lt_b}, e.lat, e.res);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_gt_msb();
        test_eq_walk();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_scan();
        test_msb_sign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
